// File: rtl/regfile_arbiter.sv
// regfile_arbiter
//   Two-requester arbiter in front of a 16 x 8 register file. Each access
//   takes three cycles: IDLE (arbitration) -> ACCESS (grant, write strobe)
//   -> RESP (done, read data available). Contested requests are served
//   round-robin; the first contest after reset is decided by A_FIRST.
//
// Ports
//   clk                 rising-edge clock
//   CLB                 asynchronous active-low reset
//   a_req/b_req         access request, held until the matching gnt
//   a_we/b_we           1 = write, 0 = read
//   a_addr/b_addr       register address
//   a_wdata/b_wdata     write data
//   a_gnt/b_gnt         one-cycle pulse during ACCESS: command captured
//   a_done/b_done       one-cycle pulse during RESP: access complete
//   a_rdata/b_rdata     last read result for that requester
//   rf_addr/rf_wdata    latched address / data to the register file
//   rf_load             register file write strobe
//   rf_rdata            register file combinational read data
module regfile_arbiter #(
  parameter bit A_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       CLB,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [3:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_gnt,
  output logic       a_done,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [3:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_gnt,
  output logic       b_done,
  output logic [7:0] b_rdata,
  output logic [3:0] rf_addr,
  output logic [7:0] rf_wdata,
  output logic       rf_load,
  input  logic [7:0] rf_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       owner_b;   // 1 when the access in flight belongs to B
  logic       prefer_b;  // winner of the next contest; reset encodes A_FIRST
  logic       we_l;
  logic [3:0] addr_l;
  logic [7:0] wdata_l;
  logic       take;
  logic       win_b;

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    win_b     = 1'b0;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          state_nxt = ACCESS;
          take      = 1'b1;
          // B wins when it is alone, or when both ask and it is B's turn
          win_b     = b_req && (!a_req || prefer_b);
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state    <= IDLE;
      owner_b  <= 1'b0;
      prefer_b <= !A_FIRST;
      we_l     <= 1'b0;
      addr_l   <= 4'd0;
      wdata_l  <= 8'd0;
      a_rdata  <= 8'd0;
      b_rdata  <= 8'd0;
    end else begin
      state <= state_nxt;
      // IDLE -> ACCESS: capture the winner's command
      if (take) begin
        owner_b  <= win_b;
        prefer_b <= !win_b;
        we_l     <= win_b ? b_we    : a_we;
        addr_l   <= win_b ? b_addr  : a_addr;
        wdata_l  <= win_b ? b_wdata : a_wdata;
      end
      // ACCESS -> RESP: return read data to the owner only
      if (state == ACCESS && !we_l) begin
        if (owner_b) b_rdata <= rf_rdata;
        else         a_rdata <= rf_rdata;
      end
    end
  end

  // Handshake pulses decode straight from state so reset clears them at once
  assign a_gnt    = (state == ACCESS) && !owner_b;
  assign b_gnt    = (state == ACCESS) &&  owner_b;
  assign a_done   = (state == RESP)   && !owner_b;
  assign b_done   = (state == RESP)   &&  owner_b;
  assign rf_load  = (state == ACCESS) &&  we_l;
  assign rf_addr  = addr_l;
  assign rf_wdata = wdata_l;

endmodule
